// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//
// Shares one UART transmitter between NUM_REQ byte sources. A round-robin
// arbiter with an optional per-requester burst lock picks the next byte. The
// block then drives the transmitter's data and transmit inputs. The
// transmitter reports no busy/done, so every frame is timed here with a
// free-running cycle counter.
//
// Frame timeline, counted from the ack edge (cnt = 0):
//   SEND : tx_transmit = 1 for HOLD = BAUD_DIV+1 cycles (cnt 0 .. HOLD-1)
//   WAIT : tx_transmit = 0 until cnt == FRAME_CYCLES-1
//   IDLE : one arbitration cycle; a grant lands on the following edge
// FRAME_CYCLES = (FRAME_BITS+1)*BAUD_DIV. The spare bit period absorbs the
// unknown phase of the transmitter's baud tick when transmit is raised.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-low reset
//   enable       in   1 = new grants allowed; the frame in flight always completes
//   req_valid    in   [NUM_REQ]    requester i offers req_data[8*i +: 8]
//   req_data     in   [8*NUM_REQ]  packed byte per requester
//   req_lock     in   [NUM_REQ]    requester wants the next grant too (sampled at ack)
//   req_ack      out  [NUM_REQ]    one-cycle pulse: byte of requester i taken
//   tx_data      out  [8]          transmitter data, stable for a whole frame
//   tx_transmit  out               transmitter transmit strobe
//   busy         out               1 while a frame is being sent or timed
//   grant_id     out  [clog2(NUM_REQ)]  last granted requester
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned BAUD_DIV   = 869,
    parameter int unsigned FRAME_BITS = 10,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [8*NUM_REQ-1:0]         req_data,
    input  logic [NUM_REQ-1:0]           req_lock,
    output logic [NUM_REQ-1:0]           req_ack,
    output logic [7:0]                   tx_data,
    output logic                         tx_transmit,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

    localparam int unsigned IdW         = $clog2(NUM_REQ);
    localparam int unsigned Hold        = BAUD_DIV + 1;
    localparam int unsigned FrameCycles = (FRAME_BITS + 1) * BAUD_DIV;
    localparam int unsigned CntW        = $clog2(FrameCycles + 1);
    localparam int unsigned BurstW      = $clog2(MAX_BURST + 1);

    localparam logic [CntW-1:0]   HoldLast  = CntW'(Hold - 1);
    localparam logic [CntW-1:0]   FrameLast = CntW'(FrameCycles - 1);
    localparam logic [BurstW-1:0] MaxBurst  = BurstW'(MAX_BURST);
    localparam logic [IdW-1:0]    LastId    = IdW'(NUM_REQ - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StSend = 2'd1;
    localparam logic [1:0] StWait = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               transmit_q, transmit_d;
    logic [IdW-1:0]     grant_id_q, grant_id_d;
    logic               lock_q, lock_d;
    logic [BurstW-1:0]  burst_q, burst_d;

    logic [IdW-1:0]     rr_win;
    logic               lock_hit;
    logic [IdW-1:0]     win;

    // Round-robin search: first valid requester at or after grant_id+1,
    // wrapping modulo NUM_REQ. Only meaningful when |req_valid.
    always_comb begin
        logic        found;
        int unsigned idx;
        found  = 1'b0;
        idx    = 0;
        rr_win = grant_id_q;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = 32'(grant_id_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!found && (i == idx) && req_valid[i]) begin
                    found  = 1'b1;
                    rr_win = IdW'(i);
                end
            end
        end
    end

    // A held lock keeps the last winner only while it still has a byte and
    // the burst has not hit its cap; otherwise round-robin takes over.
    assign lock_hit = lock_q && req_valid[grant_id_q] && (burst_q < MaxBurst);
    assign win      = lock_hit ? grant_id_q : rr_win;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ack_d      = '0;
        tx_data_d  = tx_data_q;
        transmit_d = transmit_q;
        grant_id_d = grant_id_q;
        lock_d     = lock_q;
        burst_d    = burst_q;

        case (state_q)
            StIdle: begin
                // With enable low the lock and burst state are simply kept.
                if (enable && (|req_valid)) begin
                    ack_d[win] = 1'b1;
                    tx_data_d  = req_data[{win, 3'b000} +: 8];
                    grant_id_d = win;
                    transmit_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = StSend;
                    lock_d     = req_lock[win];
                    // A locked regrant extends the burst; any other grant
                    // starts a fresh one, counting itself if it asks to lock.
                    if (lock_hit) begin
                        burst_d = burst_q + 1'b1;
                    end else begin
                        burst_d = req_lock[win] ? BurstW'(1) : '0;
                    end
                end
            end
            StSend: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == HoldLast) begin
                    transmit_d = 1'b0;
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (cnt_q == FrameLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = StIdle;
                cnt_d      = '0;
                transmit_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            ack_q      <= '0;
            tx_data_q  <= '0;
            transmit_q <= 1'b0;
            grant_id_q <= LastId;
            lock_q     <= 1'b0;
            burst_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            tx_data_q  <= tx_data_d;
            transmit_q <= transmit_d;
            grant_id_q <= grant_id_d;
            lock_q     <= lock_d;
            burst_q    <= burst_d;
        end
    end

    assign req_ack     = ack_q;
    assign tx_data     = tx_data_q;
    assign tx_transmit = transmit_q;
    assign busy        = (state_q != StIdle);
    assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
//
// Scoreboard bench. The driver applies requests and predicts each grant
// (winner, byte, ack cycle) from the arbitration rules, pushing it to a queue.
// A monitor pops an entry on every ack and also checks tx_data, grant_id,
// busy and tx_transmit against the frame timeline on every cycle.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    localparam int NUM_REQ    = 4;
    localparam int BAUD_DIV   = 4;
    localparam int FRAME_BITS = 10;
    localparam int MAX_BURST  = 16;
    localparam int HOLD       = BAUD_DIV + 1;                 // 5
    localparam int FRAME      = (FRAME_BITS + 1) * BAUD_DIV;  // 44

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        enable    = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data  = '0;
    logic [3:0]  req_lock  = '0;
    logic [3:0]  req_ack;
    logic [7:0]  tx_data;
    logic        tx_transmit;
    logic        busy;
    logic [1:0]  grant_id;

    uart_tx_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .BAUD_DIV   (BAUD_DIV),
        .FRAME_BITS (FRAME_BITS),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_lock    (req_lock),
        .req_ack     (req_ack),
        .tx_data     (tx_data),
        .tx_transmit (tx_transmit),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int         id;
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: who holds the last grant, whether it asked to lock,
    // how long its burst is, and the first cycle the block is idle again.
    int         m_gid;
    bit         m_lock;
    int         m_burst;
    int         idle_at;
    logic [7:0] dat [NUM_REQ];

    task automatic pick(input logic [3:0] v, output int w, output bit locked);
        locked = m_lock && v[m_gid] && (m_burst < MAX_BURST);
        w = m_gid;
        if (!locked) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (v[(m_gid + k) % NUM_REQ]) begin
                    w = (m_gid + k) % NUM_REQ;
                    break;
                end
            end
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a request set once the current frame is nearly done. With
    // enable high, predict the grant and wait until its ack edge has passed.
    task automatic issue(input logic [3:0] v, input logic [3:0] lk, input bit en);
        int w;
        int a;
        bit locked;
        wait_cyc(idle_at - 1);
        req_valid = v;
        req_lock  = lk;
        enable    = en;
        req_data  = {dat[3], dat[2], dat[1], dat[0]};
        if (en && (v != 4'h0)) begin
            pick(v, w, locked);
            a = ((cyc > idle_at) ? cyc : idle_at) + 1;
            exp_q.push_back('{w, dat[w], a});
            m_burst = locked ? m_burst + 1 : (lk[w] ? 1 : 0);
            m_lock  = lk[w];
            m_gid   = w;
            idle_at = a + FRAME;
            wait_cyc(a);
            dat[w] = 8'($urandom);
        end
    endtask

    task automatic model_reset();
        m_gid   = NUM_REQ - 1;
        m_lock  = 1'b0;
        m_burst = 0;
    endtask

    // Monitor
    exp_t       e;
    int         last_ack = 0;
    bit         frame_on = 1'b0;
    logic [7:0] exp_txd  = '0;
    int         exp_gid  = NUM_REQ - 1;
    int         rel;

    always @(posedge clk) begin
        #1;
        if (!reset) begin
            frame_on = 1'b0;
            exp_txd  = '0;
            exp_gid  = NUM_REQ - 1;
        end else begin
            if (req_ack != 4'h0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 64'(req_ack), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_id", 64'(req_ack), 64'd1 << e.id);
                    check("ack_cycle", 64'(cyc), 64'(e.at));
                    exp_txd  = e.data;
                    exp_gid  = e.id;
                    frame_on = 1'b1;
                    last_ack = cyc;
                end
            end
            check("tx_data", 64'(tx_data), 64'(exp_txd));
            check("grant_id", 64'(grant_id), 64'(exp_gid));
            rel = cyc - last_ack;
            if (frame_on && (rel < FRAME)) begin
                check("busy_in_frame", 64'(busy), 64'd1);
                check("tx_transmit_in_frame", 64'(tx_transmit), (rel < HOLD) ? 64'd1 : 64'd0);
            end else begin
                frame_on = 1'b0;
                check("busy_idle", 64'(busy), 64'd0);
                check("tx_transmit_idle", 64'(tx_transmit), 64'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        logic [3:0] v;
        logic [3:0] lk;

        for (int i = 0; i < NUM_REQ; i++) dat[i] = 8'($urandom);
        dat[0] = 8'hA5;
        model_reset();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_tx_transmit", 64'(tx_transmit), 64'd0);
        check("reset_ack", 64'(req_ack), 64'd0);
        check("reset_grant_id", 64'(grant_id), 64'd3);
        check("reset_tx_data", 64'(tx_data), 64'd0);
        reset   = 1'b1;
        idle_at = cyc;

        // Single byte from requester 0
        issue(4'b0001, 4'b0000, 1'b1);

        // All valid, no lock: plain rotation spaced one frame plus one cycle
        for (int n = 0; n < 5; n++) issue(4'b1111, 4'b0000, 1'b1);

        // Requester 1 locks: burst capped, then round-robin resumes
        for (int n = 0; n < 20; n++) issue(4'b0011, 4'b0010, 1'b1);

        // Locked requester withdraws while others wait
        issue(4'b0010, 4'b0010, 1'b1);
        issue(4'b1101, 4'b0000, 1'b1);

        // enable drops during SEND: frame completes, no further grant
        issue(4'b1111, 4'b0000, 1'b1);
        wait_cyc(cyc + 3);
        enable = 1'b0;
        wait_cyc(idle_at + 10);
        issue(4'b1111, 4'b0000, 1'b1);

        // Reset in the middle of a frame
        issue(4'b1111, 4'b0000, 1'b1);
        a = cyc;
        wait_cyc(a + 20);
        #2;
        reset = 1'b0;
        #1;
        check("abort_tx_transmit", 64'(tx_transmit), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ack", 64'(req_ack), 64'd0);
        check("abort_grant_id", 64'(grant_id), 64'd3);
        check("abort_tx_data", 64'(tx_data), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        reset   = 1'b1;
        model_reset();
        idle_at = cyc;
        issue(4'b0100, 4'b0000, 1'b1);

        // Randomized traffic with idle gaps, enable pauses and locks
        for (int n = 0; n < 100; n++) begin
            v  = 4'($urandom_range(1, 15));
            lk = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 5) == 0) begin
                req_valid = 4'h0;
                wait_cyc(idle_at + $urandom_range(0, 6));
            end
            if ($urandom_range(0, 9) == 0) begin
                issue(v, lk, 1'b0);
                wait_cyc(idle_at + $urandom_range(1, 6));
            end
            issue(v, lk, 1'b1);
        end

        req_valid = 4'h0;
        enable    = 1'b0;
        wait_cyc(idle_at + 4);
        check("pending_grants", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
